// File: rtl/i2c_target_regs_pkg.sv
// Shared encodings for the I2C register target: FSM states, bus events, ACK level.
package i2c_target_regs_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_PTR,
    ST_ACK_P,
    ST_WDATA,
    ST_ACK_W,
    ST_RDATA,
    ST_IGNORE
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_START,
    EV_STOP,
    EV_RISE,
    EV_FALL
  } bus_ev_e;

  localparam logic ACK = 1'b0;
  localparam logic REL = 1'b1;

endpackage

// File: rtl/i2c_target_filter.sv
// SCL/SDA synchronizer, stable-window glitch filter and bus event detector.
module i2c_target_filter
  import i2c_target_regs_pkg::*;
#(
  parameter int FILT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic [2:0] ev_o
);

  // bit 1 = SCL, bit 0 = SDA; all flops reset to the idle-high bus level
  logic [1:0] s1_q, s1_d, s2_q, s2_d, held_q, held_d, filt;

  always_comb begin
    s1_d   = {scl_i, sda_i};
    s2_d   = s1_q;
    held_d = filt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      held_q <= 2'b11;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      held_q <= held_d;
    end
  end

  generate
    if (FILT == 0) begin : g_bypass
      assign filt = s2_q;
    end else begin : g_filt
      // Level only moves once the last FILT samples all agree.
      logic [1:0][FILT-1:0] hist_q, hist_d;

      always_comb begin
        hist_d = hist_q;
        filt   = held_q;
        for (int i = 0; i < 2; i++) begin
          hist_d[i] = (hist_q[i] << 1) | FILT'(s2_q[i]);
          if (&hist_q[i])       filt[i] = 1'b1;
          else if (~|hist_q[i]) filt[i] = 1'b0;
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rst_i) hist_q <= '1;
        else        hist_q <= hist_d;
      end
    end
  endgenerate

  // START/STOP need SCL high both before and after the SDA edge
  always_comb begin
    ev_o = EV_NONE;
    if (held_q[1] && filt[1] && held_q[0] && !filt[0])      ev_o = EV_START;
    else if (held_q[1] && filt[1] && !held_q[0] && filt[0]) ev_o = EV_STOP;
    else if (!held_q[1] && filt[1])                          ev_o = EV_RISE;
    else if (held_q[1] && !filt[1])                          ev_o = EV_FALL;
  end

  assign sda_o = filt[0];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a pointer-addressed 8-bit register bank, plus a fabric write port.
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR  = 7'h48,
  parameter int         NREG_LOG2 = 3,
  parameter int         FILT      = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           scl_i,
  input  logic                           sda_i,
  output logic                           sda_oen_o,
  input  logic                           local_we_i,
  input  logic [NREG_LOG2-1:0]           local_adr_i,
  input  logic [7:0]                     local_dat_i,
  output logic [8*(2**NREG_LOG2)-1:0]    regs_o,
  output logic [(2**NREG_LOG2)-1:0]      wr_stb_o,
  output logic                           busy_o
);

  localparam int NREG = 2**NREG_LOG2;

  logic [2:0] ev_raw;
  bus_ev_e    ev;
  logic       sda_f;

  i2c_target_filter #(.FILT(FILT)) u_filter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .scl_i (scl_i),
    .sda_i (sda_i),
    .sda_o (sda_f),
    .ev_o  (ev_raw)
  );

  assign ev = bus_ev_e'(ev_raw);

  state_e                    state_q, state_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [7:0]                shreg_q, shreg_d;
  logic [6:0]                tx_q, tx_d;
  logic [NREG_LOG2-1:0]      ptr_q, ptr_d;
  logic                      oen_q, oen_d;
  logic                      busy_q, busy_d;
  logic                      rw_q, rw_d;
  logic [NREG-1:0][7:0]      regs_q, regs_d;
  logic [NREG-1:0]           wr_stb_q, wr_stb_d;
  logic                      i2c_we;
  logic [7:0]                rx_byte;

  assign rx_byte = {shreg_q[6:0], sda_f};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    oen_d     = oen_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    i2c_we    = 1'b0;

    case (ev)
      EV_START: begin
        state_d   = ST_ADDR;
        bit_cnt_d = '0;
        oen_d     = REL;
      end
      EV_STOP: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        oen_d     = REL;
        busy_d    = 1'b0;
      end
      EV_RISE: begin
        case (state_q)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (bit_cnt_q < 4'd8) begin
              shreg_d   = rx_byte;
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                if (state_q == ST_PTR) ptr_d = rx_byte[NREG_LOG2-1:0];
                if (state_q == ST_WDATA) begin
                  i2c_we = 1'b1;
                  ptr_d  = ptr_q + NREG_LOG2'(1);
                end
              end
            end
          end
          ST_RDATA: begin
            if (bit_cnt_q == 4'd8) begin
              // master's acknowledge bit
              bit_cnt_d = 4'd9;
              if (sda_f == ACK) begin
                ptr_d = ptr_q + NREG_LOG2'(1);
              end else begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            end else if (bit_cnt_q < 4'd8) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
          default: ;
        endcase
      end
      EV_FALL: begin
        case (state_q)
          ST_ADDR: begin
            if (bit_cnt_q == 4'd8) begin
              if (shreg_q[7:1] == I2C_ADDR) begin
                state_d = ST_ACK_A;
                oen_d   = ACK;
                busy_d  = 1'b1;
                rw_d    = shreg_q[0];
              end else begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
          ST_PTR: begin
            if (bit_cnt_q == 4'd8) begin
              state_d = ST_ACK_P;
              oen_d   = ACK;
            end
          end
          ST_WDATA: begin
            if (bit_cnt_q == 4'd8) begin
              state_d = ST_ACK_W;
              oen_d   = ACK;
            end
          end
          ST_ACK_A: begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d = ST_RDATA;
              tx_d    = regs_q[ptr_q][6:0];
              oen_d   = regs_q[ptr_q][7];
            end else begin
              state_d = ST_PTR;
              oen_d   = REL;
            end
          end
          ST_ACK_P, ST_ACK_W: begin
            state_d   = ST_WDATA;
            bit_cnt_d = '0;
            oen_d     = REL;
          end
          ST_RDATA: begin
            if (bit_cnt_q == 4'd9) begin
              // acked: pointer already advanced on the ack clock
              bit_cnt_d = '0;
              tx_d      = regs_q[ptr_q][6:0];
              oen_d     = regs_q[ptr_q][7];
            end else if (bit_cnt_q == 4'd8) begin
              oen_d = REL;
            end else if (bit_cnt_q != 4'd0) begin
              oen_d = tx_q[6];
              tx_d  = {tx_q[5:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // I2C write is applied after the local one so it wins on a collision
  always_comb begin
    regs_d   = regs_q;
    wr_stb_d = '0;
    for (int k = 0; k < NREG; k++) begin
      if (local_we_i && local_adr_i == NREG_LOG2'(k)) regs_d[k] = local_dat_i;
      if (i2c_we && ptr_q == NREG_LOG2'(k)) begin
        regs_d[k]   = rx_byte;
        wr_stb_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      oen_q     <= REL;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      regs_q    <= '0;
      wr_stb_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      oen_q     <= oen_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
    end
  end

  assign sda_oen_o = oen_q;
  assign busy_o    = busy_q;
  assign regs_o    = regs_q;
  assign wr_stb_o  = wr_stb_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master driving i2c_target_regs; scoreboard queues for SDA bits and write strobes.
module tb_i2c_target_regs;

  localparam int FILT = 2;
  localparam int Q    = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oen_o;
  logic       lwe;
  logic [2:0] ladr;
  logic [7:0] ldat;
  logic [63:0] regs_o;
  logic [7:0] wr_stb_o;
  logic       busy_o;

  always #5 clk = ~clk;

  assign sda_line = sda_m & sda_oen_o;

  i2c_target_regs #(.I2C_ADDR(7'h48), .NREG_LOG2(3), .FILT(FILT)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .scl_i       (scl_m),
    .sda_i       (sda_line),
    .sda_oen_o   (sda_oen_o),
    .local_we_i  (lwe),
    .local_adr_i (ladr),
    .local_dat_i (ldat),
    .regs_o      (regs_o),
    .wr_stb_o    (wr_stb_o),
    .busy_o      (busy_o)
  );

  typedef struct { logic exp; string tag; } bit_exp_t;
  typedef struct { int idx; logic [7:0] dat; } wr_exp_t;

  bit_exp_t   bq[$];
  wr_exp_t    wq[$];
  logic [7:0] exp_regs [8];
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_reg%0d", tag, i), {56'd0, regs_o[8*i +: 8]}, {56'd0, exp_regs[i]});
  endtask

  // One SCL clock; the DUT's SDA enable during the high phase is scoreboarded.
  task automatic send_bit(input logic b, input logic exp_oen, input string tag,
                          input logic coll, input logic [2:0] cadr, input logic [7:0] cdat);
    bit_exp_t e;
    sda_m = b;
    e.exp = exp_oen;
    e.tag = tag;
    bq.push_back(e);
    tick(Q);
    scl_m = 1'b1;
    if (coll) begin
      // lands the local write in the same cycle the target commits the byte
      tick(2 + FILT);
      lwe = 1'b1; ladr = cadr; ldat = cdat;
      tick(1);
      lwe = 1'b0;
      tick(2*Q - 3 - FILT);
    end else begin
      tick(2*Q);
    end
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic wr_byte_c(input logic [7:0] b, input logic exp_ack, input string tag,
                           input logic coll, input logic [2:0] cadr, input logic [7:0] cdat);
    for (int i = 7; i >= 0; i--)
      send_bit(b[i], 1'b1, tag, (i == 0) ? coll : 1'b0, cadr, cdat);
    send_bit(1'b1, exp_ack, {tag, "_ack"}, 1'b0, 3'd0, 8'd0);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    wr_byte_c(b, exp_ack, tag, 1'b0, 3'd0, 8'd0);
  endtask

  task automatic rd_byte(input logic [7:0] exp, input logic mack, input string tag);
    for (int i = 7; i >= 0; i--) send_bit(1'b1, exp[i], tag, 1'b0, 3'd0, 8'd0);
    send_bit(mack, 1'b1, {tag, "_mack"}, 1'b0, 3'd0, 8'd0);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2*Q);
  endtask

  task automatic push_wr(input int idx, input logic [7:0] dat);
    wr_exp_t w;
    w.idx = idx;
    w.dat = dat;
    wq.push_back(w);
  endtask

  // SDA monitor: DUT enable level while SCL is high
  initial begin
    bit_exp_t e;
    forever begin
      @(posedge scl_m);
      @(negedge clk);
      if (bq.size() > 0) begin
        e = bq.pop_front();
        chk(e.tag, {63'd0, sda_oen_o}, {63'd0, e.exp});
      end
    end
  end

  // Write-strobe monitor
  initial begin
    wr_exp_t w;
    forever begin
      @(negedge clk);
      if (wr_stb_o != 8'd0) begin
        if (wq.size() == 0) begin
          chk("wr_stb_unexpected", {56'd0, wr_stb_o}, 64'd0);
        end else begin
          w = wq.pop_front();
          chk($sformatf("wr_stb_%0d", w.idx), {56'd0, wr_stb_o}, 64'd1 << w.idx);
          chk($sformatf("wr_dat_%0d", w.idx), {56'd0, regs_o[8*w.idx +: 8]}, {56'd0, w.dat});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    lwe = 1'b0; ladr = 3'd0; ldat = 8'd0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    tick(4);
    chk("rst_oen",  {63'd0, sda_oen_o}, 64'd1);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_stb",  {56'd0, wr_stb_o}, 64'd0);
    chk("rst_regs", regs_o, 64'd0);
    rst_n = 1'b1;
    tick(Q);

    // 1: write two bytes from pointer 2
    bus_start();
    wr_byte(8'h90, 1'b0, "t1_adr");
    chk("t1_busy_on", {63'd0, busy_o}, 64'd1);
    wr_byte(8'h02, 1'b0, "t1_ptr");
    push_wr(2, 8'hA5); wr_byte(8'hA5, 1'b0, "t1_d0");
    push_wr(3, 8'h5A); wr_byte(8'h5A, 1'b0, "t1_d1");
    bus_stop();
    exp_regs[2] = 8'hA5; exp_regs[3] = 8'h5A;
    chk_regs("t1");
    chk("t1_busy_off", {63'd0, busy_o}, 64'd0);

    // 2: set pointer, repeated START, read with ACK then NACK
    bus_start();
    wr_byte(8'h90, 1'b0, "t2_adr");
    wr_byte(8'h03, 1'b0, "t2_ptr");
    bus_start();
    wr_byte(8'h91, 1'b0, "t2_radr");
    rd_byte(8'h5A, 1'b0, "t2_rd0");
    rd_byte(8'h00, 1'b1, "t2_rd1");
    chk("t2_busy_nack", {63'd0, busy_o}, 64'd0);
    chk("t2_oen_nack",  {63'd0, sda_oen_o}, 64'd1);
    bus_stop();

    // 3: wrong address is never acknowledged
    bus_start();
    wr_byte(8'h92, 1'b1, "t3_adr");
    chk("t3_busy", {63'd0, busy_o}, 64'd0);
    bus_stop();
    chk_regs("t3");

    // 4: pointer wrap and upper pointer bits discarded
    bus_start();
    wr_byte(8'h90, 1'b0, "t4_adr");
    wr_byte(8'h07, 1'b0, "t4_ptr");
    push_wr(7, 8'h11); wr_byte(8'h11, 1'b0, "t4_d0");
    push_wr(0, 8'h22); wr_byte(8'h22, 1'b0, "t4_d1");
    bus_stop();
    bus_start();
    wr_byte(8'h90, 1'b0, "t4b_adr");
    wr_byte(8'hFB, 1'b0, "t4b_ptr");
    push_wr(3, 8'h99); wr_byte(8'h99, 1'b0, "t4b_d0");
    bus_stop();
    exp_regs[7] = 8'h11; exp_regs[0] = 8'h22; exp_regs[3] = 8'h99;
    chk_regs("t4");

    // 5: same-cycle local writes, same register then a different one
    bus_start();
    wr_byte(8'h90, 1'b0, "t5_adr");
    wr_byte(8'h01, 1'b0, "t5_ptr");
    push_wr(1, 8'h33); wr_byte_c(8'h33, 1'b0, "t5_d0", 1'b1, 3'd1, 8'h77);
    push_wr(2, 8'h44); wr_byte_c(8'h44, 1'b0, "t5_d1", 1'b1, 3'd5, 8'h66);
    bus_stop();
    exp_regs[1] = 8'h33; exp_regs[2] = 8'h44; exp_regs[5] = 8'h66;
    chk_regs("t5");

    // 6: reset while the target is driving a 0 data bit
    bus_start();
    wr_byte(8'h90, 1'b0, "t6_adr");
    wr_byte(8'h01, 1'b0, "t6_ptr");
    bus_start();
    wr_byte(8'h91, 1'b0, "t6_radr");
    chk("t6_driving", {63'd0, sda_oen_o}, 64'd0);
    rst_n = 1'b0;
    tick(1);
    chk("t6_oen_rel", {63'd0, sda_oen_o}, 64'd1);
    chk("t6_busy",    {63'd0, busy_o}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    chk_regs("t6");
    tick(Q);
    bus_start();
    wr_byte(8'h91, 1'b0, "t6b_radr");
    rd_byte(8'h00, 1'b1, "t6b_rd0");
    bus_stop();

    tick(2*Q);
    chk("bitq_empty", 64'(bq.size()), 64'd0);
    chk("wrq_empty",  64'(wq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
I2C target (responder) with an 8-entry, 8-bit register bank, clocked from the system clock. It is the far end of the I2C master/crossbar path: it answers one 7-bit address and provides pointer-based register write/read. Fabric logic gets all registers in parallel, plus a local write port and per-register write strobes. It is used for board-level loopback, bench emulation of I2C peripherals, and exposing status to an external controller.

Parameters:
I2C_ADDR, 7'h48, 7-bit target address matched after START.
NREG_LOG2, 3, log2 of register count; bank has 2**NREG_LOG2 entries.
FILT, 2, SCL/SDA input filter depth in clk_i cycles; 0 disables the filter.

Ports:
clk_i  input  1  system clock, all logic on rising edge.
rst_i  input  1  synchronous, active-low reset.
scl_i  input  1  SCL pad input, asynchronous.
sda_i  input  1  SDA pad input, asynchronous.
sda_oen_o  output  1  1 releases SDA; 0 drives SDA low. The pad output is tied to 0 outside this block.
local_we_i  input  1  fabric write strobe.
local_adr_i  input  NREG_LOG2  fabric write register index.
local_dat_i  input  8  fabric write data.
regs_o  output  8*2**NREG_LOG2  flattened register bank; reg k is at bits [8k+7:8k].
wr_stb_o  output  2**NREG_LOG2  one-cycle pulse per register written from the I2C side.
busy_o  output  1  high from addressed START until STOP or NACK-release.

Behaviour:
- Reset (rst_i=0 at clk edge), for all outputs:
  - sda_oen_o=1, wr_stb_o=0, busy_o=0, all registers 8'h00.
  - pointer=0, state=IDLE.
  - Synchronizer flops are set to 1 (bus idle).
  - Reset mid-transfer releases SDA on the next cycle and ignores the bus until the next START.
- Input conditioning:
  - 2-FF synchronizer, then FILT-cycle majority/stable filter.
  - Rising and falling edges are detected on the filtered signals.
  - Latency from pad to edge event is 2+FILT cycles.
- Bus events:
  - START: filtered SDA falls while SCL is high.
  - STOP: filtered SDA rises while SCL is high.
  - START and STOP are recognised in every state, including a repeated START. They reset the bit counter and go to ADDR (START) or IDLE (STOP).
- Bit timing:
  - Data is sampled on the SCL rising event.
  - sda_oen_o changes only on the SCL falling event (one cycle after it).
  - No clock stretching.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (MSB first).
    - If bits[7:1]==I2C_ADDR, go to ACK_A and drive ACK.
    - Otherwise go to IGNORE: SDA stays released until the next START or STOP.
  - ACK_A: after the ACK clock falls:
    - R/W=0: go to PTR.
    - R/W=1: load the read shifter from regs[pointer] and go to RDATA.
  - PTR: receive 8 bits; pointer takes the low NREG_LOG2 bits; ACK; then go to WDATA.
  - WDATA: receive a byte; ACK it.
    - On the 8th rising edge, write regs[pointer], pulse wr_stb_o[pointer], increment pointer.
    - Repeat.
  - RDATA: drive bits MSB first (oen=bit value), then release for the master's ACK bit.
    - Sampled ACK=0: increment pointer, reload, continue.
    - NACK: go to IGNORE.
- Pointer arithmetic: modulo 2**NREG_LOG2 (wraps 7→0). The upper pointer-byte bits are discarded.
- Collision: an I2C write and local_we_i to the same register in the same cycle resolves to the I2C data. Different registers are both written.
- busy_o rises on the address ACK and falls on STOP, START-to-other-address, or NACK.

Decomposition:
- Shared package: state encoding, START/STOP/edge event constants, ACK=1'b0 constant.
- Sub-module i2c_target_filter: synchronizer, glitch filter and edge/START/STOP detector. Instantiated once and reused by future targets.

Test Plan:
1. Write: START, 0x90 (0x48<<1|0), ptr 0x02, 0xA5, 0x5A, STOP → ACK on all 4 bytes; regs[2]=A5, regs[3]=5A; wr_stb_o pulses bit2 then bit3; busy_o falls after STOP.
2. Read with repeated START: write ptr 0x03, rSTART, 0x91, master ACKs once then NACKs → SDA returns 0x5A then 0x00 (reg4); SDA released after NACK.
3. Wrong address: START, 0x92 → no ACK; sda_oen_o stays 1 through 9 clocks; registers unchanged; busy_o=0.
4. Wrap: ptr 0x07, data 0x11, 0x22 → regs[7]=11, regs[0]=22; ptr byte 0xFB behaves as pointer 3.
5. Collision: local_we_i to reg1 with 0x77 in the same cycle as an I2C write of 0x33 to reg1 → regs[1]=0x33; local write to reg5 in the same cycle also lands.
6. Reset mid-read: assert rst_i=0 while driving a 0 bit → sda_oen_o=1 next cycle, regs cleared; the next START/0x91 reads reg0=0x00.
